// File: rtl/sram_arbiter.sv
// Three-client (video/CPU/DMA) slot arbiter in front of the SRAM controller.
// Grants on cyc strobes, routes read words back, bounds DMA starvation.
module sram_arbiter #(
  parameter int DMA_MAXWAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        vid_req,
  input  logic [20:0] vid_addr,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [20:0] cpu_addr,
  input  logic [15:0] cpu_wrdata,
  input  logic [1:0]  cpu_bsel,
  input  logic        dma_req,
  input  logic        dma_rnw,
  input  logic [20:0] dma_addr,
  input  logic [15:0] dma_wrdata,
  input  logic [1:0]  dma_bsel,
  output logic        vid_ack,
  output logic        cpu_ack,
  output logic        dma_ack,
  output logic [15:0] rd_data,
  output logic        vid_strb,
  output logic        cpu_strb,
  output logic        dma_strb,
  output logic        req,
  output logic [20:0] addr,
  output logic        rnw,
  output logic [1:0]  bsel,
  output logic [15:0] wrdata,
  input  logic [15:0] sram_do
);

  typedef enum logic [1:0] {
    ID_NONE,
    ID_VID,
    ID_CPU,
    ID_DMA
  } id_e;

  localparam logic [3:0] MAXW = 4'(DMA_MAXWAIT);

  id_e         win;
  logic        grant;
  logic        ret;
  logic [2:0]  ack_q, ack_d;
  logic [2:0]  strb_q, strb_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [15:0] wrdata_q, wrdata_d;
  logic        pend_rd_q, pend_rd_d;
  id_e         pend_id_q, pend_id_d;
  logic [3:0]  wait_q, wait_d;

  function automatic logic [2:0] onehot(id_e id);
    logic [2:0] v;
    v = 3'b000;
    case (id)
      ID_VID:  v = 3'b001;
      ID_CPU:  v = 3'b010;
      ID_DMA:  v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // Fixed priority, except a starved DMA jumps ahead of the CPU.
  always_comb begin
    win = ID_NONE;
    if (vid_req)
      win = ID_VID;
    else if (dma_req && wait_q == MAXW)
      win = ID_DMA;
    else if (cpu_req)
      win = ID_CPU;
    else if (dma_req)
      win = ID_DMA;
  end

  always_comb begin
    addr = '0;
    rnw  = 1'b1;
    bsel = '0;
    case (win)
      ID_VID: begin
        addr = vid_addr;
        bsel = 2'b11;
      end
      ID_CPU: begin
        addr = cpu_addr;
        rnw  = cpu_rnw;
        bsel = cpu_bsel;
      end
      ID_DMA: begin
        addr = dma_addr;
        rnw  = dma_rnw;
        bsel = dma_bsel;
      end
      default: ;
    endcase
  end

  assign req   = vid_req | cpu_req | dma_req;
  assign grant = cyc & req;
  assign ret   = cyc & pend_rd_q;

  always_comb begin
    ack_d     = '0;
    strb_d    = '0;
    rd_data_d = rd_data_q;
    wrdata_d  = wrdata_q;
    pend_rd_d = pend_rd_q;
    pend_id_d = pend_id_q;
    wait_d    = wait_q;
    if (grant)
      ack_d = onehot(win);
    if (ret) begin
      rd_data_d = sram_do;
      strb_d    = onehot(pend_id_q);
      pend_rd_d = 1'b0;
      pend_id_d = ID_NONE;
    end
    // A read granted on the return edge takes over the pending slot.
    if (grant && rnw) begin
      pend_rd_d = 1'b1;
      pend_id_d = win;
    end
    if (grant && !rnw)
      wrdata_d = (win == ID_CPU) ? cpu_wrdata : dma_wrdata;
    if (cyc) begin
      if (!dma_req || win == ID_DMA)
        wait_d = '0;
      else if (win == ID_CPU && wait_q != MAXW)
        wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q     <= '0;
      strb_q    <= '0;
      rd_data_q <= '0;
      wrdata_q  <= '0;
      pend_rd_q <= 1'b0;
      pend_id_q <= ID_NONE;
      wait_q    <= '0;
    end else begin
      ack_q     <= ack_d;
      strb_q    <= strb_d;
      rd_data_q <= rd_data_d;
      wrdata_q  <= wrdata_d;
      pend_rd_q <= pend_rd_d;
      pend_id_q <= pend_id_d;
      wait_q    <= wait_d;
    end
  end

  assign vid_ack  = ack_q[0];
  assign cpu_ack  = ack_q[1];
  assign dma_ack  = ack_q[2];
  assign vid_strb = strb_q[0];
  assign cpu_strb = strb_q[1];
  assign dma_strb = strb_q[2];
  assign rd_data  = rd_data_q;
  assign wrdata   = wrdata_q;

endmodule
